cdiv32: RTL and testbench

CDIV32 -- requirements
Module: cdiv32

---
 rtl/cdiv32_pkg.sv | 30 +++
 rtl/udiv33_step.sv | 29 ++
 rtl/cdiv32.sv | 144 ++++++++++++++
 tb/tb_cdiv32.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cdiv32_pkg.sv
// Shared definitions for the packed-complex arithmetic family: field positions,
// divider iteration count, FSM encoding and quotient finishing helpers.
package cdiv32_pkg;

  localparam int RE_HI = 31;
  localparam int RE_LO = 16;
  localparam int IM_HI = 15;
  localparam int IM_LO = 0;

  localparam int         ITERS     = 33;
  localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREP   = 3'd1,
    DIV_RE = 3'd2,
    DIV_IM = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Low 16 bits of the signed quotient rebuilt from magnitude and sign.
  function automatic logic [15:0] wrap_half(input logic [32:0] q, input logic neg);
    return neg ? (16'd0 - q[15:0]) : q[15:0];
  endfunction

  function automatic logic half_ovf(input logic [32:0] q, input logic neg);
    return neg ? (q > 33'd32768) : (q > 33'd32767);
  endfunction

endpackage

// File: rtl/udiv33_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and emit one quotient bit.
module udiv33_step
  import cdiv32_pkg::*;
(
  input  logic [31:0] rem_in,
  input  logic        bit_in,
  input  logic [31:0] m,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  logic [32:0] trial_s;
  logic [31:0] diff_s;

  // The remainder stays below m, so the difference always fits in 32 bits.
  always_comb begin
    trial_s = {rem_in, bit_in};
    diff_s  = trial_s[31:0] - m;
    if (trial_s >= {1'b0, m}) begin
      q_bit   = 1'b1;
      rem_out = diff_s;
    end else begin
      q_bit   = 1'b0;
      rem_out = trial_s[31:0];
    end
  end

endmodule

// File: rtl/cdiv32.sv
// Packed complex divider q = n / d computed as n*conj(d) / |d|^2, with both
// quotient halves produced by one time-shared restoring divider.
module cdiv32
  import cdiv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] o,
  output logic        dz,
  output logic        ovf
);

  state_t      state_r;
  logic [31:0] num_r, den_r, m_r, rem_r;
  logic [32:0] dvd_r, q_re_r, ni_abs_r;
  logic        nr_neg_r, ni_neg_r, zero_r;
  logic [5:0]  cnt_r;

  logic signed [15:0] a_s, b_s, c_s, d_s;
  logic signed [31:0] ac_s, bd_s, bc_s, ad_s, cc_s, dd_s;
  logic signed [32:0] nr_s, ni_s;
  logic [32:0]        nr_abs_s, ni_abs_s;
  logic [31:0]        m_s, step_rem_s;
  logic               step_q_s;

  // Full-precision products and numerator terms of n * conj(d).
  always_comb begin
    a_s      = num_r[RE_HI:RE_LO];
    b_s      = num_r[IM_HI:IM_LO];
    c_s      = den_r[RE_HI:RE_LO];
    d_s      = den_r[IM_HI:IM_LO];
    ac_s     = a_s * c_s;
    bd_s     = b_s * d_s;
    bc_s     = b_s * c_s;
    ad_s     = a_s * d_s;
    cc_s     = c_s * c_s;
    dd_s     = d_s * d_s;
    nr_s     = {ac_s[31], ac_s} + {bd_s[31], bd_s};
    ni_s     = {bc_s[31], bc_s} - {ad_s[31], ad_s};
    m_s      = $unsigned(cc_s) + $unsigned(dd_s);
    nr_abs_s = nr_s[32] ? (33'd0 - nr_s) : nr_s;
    ni_abs_s = ni_s[32] ? (33'd0 - ni_s) : ni_s;
  end

  udiv33_step u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[32]),
    .m       (m_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      o         <= 32'd0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      num_r     <= 32'd0;
      den_r     <= 32'd0;
      m_r       <= 32'd0;
      rem_r     <= 32'd0;
      dvd_r     <= 33'd0;
      q_re_r    <= 33'd0;
      ni_abs_r  <= 33'd0;
      nr_neg_r  <= 1'b0;
      ni_neg_r  <= 1'b0;
      zero_r    <= 1'b0;
      cnt_r     <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            num_r    <= num;
            den_r    <= den;
            in_ready <= 1'b0;
            state_r  <= PREP;
          end
        end
        PREP: begin
          zero_r   <= (den_r == 32'd0);
          m_r      <= m_s;
          nr_neg_r <= nr_s[32];
          ni_neg_r <= ni_s[32];
          ni_abs_r <= ni_abs_s;
          dvd_r    <= nr_abs_s;
          rem_r    <= 32'd0;
          cnt_r    <= 6'd0;
          state_r  <= (den_r == 32'd0) ? DONE : DIV_RE;
        end
        DIV_RE, DIV_IM: begin
          rem_r <= step_rem_s;
          dvd_r <= {dvd_r[31:0], step_q_s};
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LAST_ITER) begin
            cnt_r <= 6'd0;
            if (state_r == DIV_RE) begin
              // Park the real quotient and restart the divider on |ni|.
              q_re_r  <= {dvd_r[31:0], step_q_s};
              dvd_r   <= ni_abs_r;
              rem_r   <= 32'd0;
              state_r <= DIV_IM;
            end else begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (zero_r) begin
              o   <= 32'd0;
              dz  <= 1'b1;
              ovf <= 1'b0;
            end else begin
              o   <= {wrap_half(q_re_r, nr_neg_r), wrap_half(dvd_r, ni_neg_r)};
              dz  <= 1'b0;
              ovf <= half_ovf(q_re_r, nr_neg_r) | half_ovf(dvd_r, ni_neg_r);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdiv32.sv
// Self-checking bench for cdiv32: directed vectors, random operands against an
// integer-arithmetic complex-division model, backpressure and reset abort.
module tb_cdiv32;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, dz, ovf;
  logic [31:0] num, den, o;

  int checks = 0;
  int errors = 0;

  cdiv32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact complex division with C-style truncation toward zero.
  function automatic void model(input logic [31:0] n, input logic [31:0] d,
                                output logic [31:0] eo, output logic edz, output logic eovf);
    longint a, b, c, dd, nr, ni, m, qr, qi;
    logic [63:0] tr, ti;
    a  = longint'($signed(n[31:16]));
    b  = longint'($signed(n[15:0]));
    c  = longint'($signed(d[31:16]));
    dd = longint'($signed(d[15:0]));
    if (c == 0 && dd == 0) begin
      eo = 32'd0; edz = 1'b1; eovf = 1'b0;
    end else begin
      nr = a * c + b * dd;
      ni = b * c - a * dd;
      m  = c * c + dd * dd;
      qr = nr / m;
      qi = ni / m;
      tr = qr;
      ti = qi;
      eo   = {tr[15:0], ti[15:0]};
      edz  = 1'b0;
      eovf = (qr > 32767 || qr < -32768 || qi > 32767 || qi < -32768);
    end
  endfunction

  task automatic accept(input logic [31:0] n, input logic [31:0] d);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    num = n; den = d; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    num = $urandom; den = $urandom;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] n, input logic [31:0] d, input int hold);
    logic [31:0] eo;
    logic        edz, eovf;
    int          cyc = 0;
    model(n, d, eo, edz, eovf);
    accept(n, d);
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("latency", cyc, edz ? 32'd2 : 32'd68);
    check("o", o, eo);
    check("dz", {31'd0, dz}, {31'd0, edz});
    check("ovf", {31'd0, ovf}, {31'd0, eovf});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_o", o, eo);
      check("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
    end
    // Offer a new pair during the handshake cycle; it must not be taken.
    in_valid = 1'b1; out_ready = 1'b1; num = $urandom; den = 32'h00010000;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("release_valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] small_pair();
    logic [15:0] re, im;
    re = 16'($signed($urandom_range(16, 0)) - 8);
    im = 16'($signed($urandom_range(16, 0)) - 8);
    return {re, im};
  endfunction

  initial begin
    int seen;
    logic [31:0] rn, rd;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num = 32'd0; den = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_hs", {30'd0, in_ready, out_valid}, 32'd2);
    check("reset_o", o, 32'd0);
    check("reset_flags", {30'd0, dz, ovf}, 32'd0);

    run_op(32'h000A0005, 32'h00010002, 0);
    run_op(32'hFFF90000, 32'h00020000, 0);
    run_op(32'h80000000, 32'hFFFF0000, 0);
    run_op(32'h12345678, 32'h00000000, 0);
    run_op(32'h7FFF8000, 32'h00030005, 10);

    // Abort during the imaginary division.
    accept(32'h00640032, 32'h00030004);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_hs", {30'd0, in_ready, out_valid}, 32'd2);
    check("abort_o", o, 32'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 32'd0);
    run_op(32'h00640032, 32'h00030004, 2);

    for (int i = 0; i < 24; i++) begin
      rn = $urandom;
      rd = (i % 3 == 0) ? $urandom : small_pair();
      if (i % 3 == 1) rn = small_pair() << 4;
      run_op(rn, rd, $urandom_range(2, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
